input_port_controller: RTL and testbench

Producer side of the processor's `IN` data path. When the control unit executes an input instruction, this block waits for the operator to confirm a value on the board switches with the enter key. It debounces the key, latches the switch word and presents it on `IN` for the write-back mux. It signals completion with a one-cycle `inReady` pulse, which releases the processor stall.

---
 rtl/io_pkg.sv | 17 +
 rtl/key_debouncer.sv | 76 +++++++
 rtl/input_port_controller.sv | 138 +++++++++++++
 tb/tb_input_port_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the processor I/O controllers: the default data widths
// and the input-port sequencing states.
package io_pkg;

   localparam int BITS_DEFAULT = 32;
   localparam int SW_DEFAULT   = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RELEASE  = 3'd1,
      ARMED    = 3'd2,
      DEBOUNCE = 3'd3,
      CAPTURE  = 3'd4,
      DONE     = 3'd5
   } ctrl_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Enter-key conditioning: two-flop synchronizer, saturating run-length counter
// and a single-cycle press strobe. The counter only runs while clear is low and
// the synchronized key is high; any low sample restarts it from zero.
module key_debouncer #(
   parameter int DB_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   input  logic clear,
   input  logic arm,
   output logic key_sync,
   output logic pressed
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] count;
   logic             need_release;
   logic             fired;

   // Bring the raw button into the clock domain before anything looks at it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= key_raw;
         sync_q    <= sync_meta;
      end
   end

   // Count consecutive high samples; saturate at the terminal value instead of wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || !sync_q) begin
         count <= '0;
      end else if (count != CNT_LAST) begin
         count <= count + 1'b1;
      end
   end

   // A key held when arming must be seen released before it can count as a press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         need_release <= 1'b0;
      end else if (arm) begin
         need_release <= 1'b1;
      end else if (!sync_q) begin
         need_release <= 1'b0;
      end
   end

   // Remember that this run already produced its strobe so it fires only once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fired <= 1'b0;
      end else if (clear || !sync_q) begin
         fired <= 1'b0;
      end else if (pressed) begin
         fired <= 1'b1;
      end
   end

   // Strobe on the cycle the run reaches its terminal count with the key still high.
   always_comb begin
      pressed = sync_q && !clear && !need_release && !fired && (count == CNT_LAST);
   end

   assign key_sync = sync_q;

endmodule

// File: rtl/input_port_controller.sv
// Producer side of the IN data path: waits for a debounced enter-key press while
// the control unit requests input, latches the (extended) switch word and pulses
// inReady for one cycle to release the processor stall.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request pending
// RELEASE  | request seen with key already down; wait for it to go up
// ARMED    | request pending, key up; waiting for a press to start
// DEBOUNCE | key high, counting consecutive high cycles
// CAPTURE  | press accepted; IN and inReady load on this edge
// DONE     | inReady high for its single cycle; return to IDLE
module input_port_controller
   import io_pkg::*;
#(
   parameter int bits      = BITS_DEFAULT,
   parameter int sw        = SW_DEFAULT,
   parameter int DB_CYCLES = 50000,
   parameter int SIGNED    = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flagIN,
   input  logic [sw-1:0]   switches,
   input  logic            enterKey,
   output logic [bits-1:0] IN,
   output logic            inReady,
   output logic            waiting
);

   ctrl_state_t     state;
   ctrl_state_t     state_n;
   logic            keyS;
   logic            pressed;
   logic            db_clear;
   logic            db_arm;
   logic            ext_fill;
   logic [bits-1:0] ext_word;

   key_debouncer #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debouncer (
      .clock    (clock),
      .reset    (reset),
      .key_raw  (enterKey),
      .clear    (db_clear),
      .arm      (db_arm),
      .key_sync (keyS),
      .pressed  (pressed)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state, debouncer control and operator LED; a dropped request aborts any pre-capture state.
   always_comb begin
      state_n  = state;
      db_clear = 1'b1;
      db_arm   = 1'b0;
      waiting  = 1'b0;
      case (state)
         IDLE: begin
            if (flagIN) begin
               if (keyS) begin
                  state_n = RELEASE;
                  db_arm  = 1'b1;
               end else begin
                  state_n = ARMED;
               end
            end
         end
         RELEASE: begin
            waiting = 1'b1;
            if (!flagIN) begin
               state_n = IDLE;
            end else if (!keyS) begin
               state_n = ARMED;
            end
         end
         ARMED: begin
            waiting = 1'b1;
            if (!flagIN) begin
               state_n = IDLE;
            end else if (keyS) begin
               state_n = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            waiting  = 1'b1;
            db_clear = 1'b0;
            if (!flagIN) begin
               state_n = IDLE;
            end else if (!keyS) begin
               state_n = ARMED;
            end else if (pressed) begin
               state_n = CAPTURE;
            end
         end
         CAPTURE: begin
            waiting = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Widen the switch word: zero fill, or replicate its top bit when SIGNED is set.
   always_comb begin
      ext_fill           = (SIGNED != 0) ? switches[sw-1] : 1'b0;
      ext_word           = {bits{ext_fill}};
      ext_word[sw-1:0]   = switches;
   end

   // Output word and completion pulse both load on the CAPTURE edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         IN      <= '0;
         inReady <= 1'b0;
      end else begin
         inReady <= (state == CAPTURE);
         if (state == CAPTURE) begin
            IN <= ext_word;
         end
      end
   end

endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller with DB_CYCLES=4, sw=16, bits=32. Two instances
// (zero- and sign-extending) share all inputs; a scoreboard of expected captures
// is checked against every inReady pulse.
module tb_input_port_controller;

   localparam int DB  = 4;
   localparam int LAT = DB + 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flagIN = 1'b0;
   logic [15:0] switches = 16'h0000;
   logic        enterKey = 1'b0;
   logic [31:0] in_u;
   logic [31:0] in_s;
   logic        rdy_u;
   logic        rdy_s;
   logic        wait_u;
   logic        wait_s;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   logic prev_waiting = 1'b0;
   logic [31:0] last_u = 32'h0;
   logic [31:0] last_s = 32'h0;

   typedef struct {
      logic [31:0] d_u;
      logic [31:0] d_s;
      int          at;
   } exp_t;

   exp_t sbq[$];

   input_port_controller #(
      .bits(32), .sw(16), .DB_CYCLES(DB), .SIGNED(0)
   ) dut (
      .clock(clock), .reset(reset), .flagIN(flagIN), .switches(switches),
      .enterKey(enterKey), .IN(in_u), .inReady(rdy_u), .waiting(wait_u)
   );

   input_port_controller #(
      .bits(32), .sw(16), .DB_CYCLES(DB), .SIGNED(1)
   ) dut_s (
      .clock(clock), .reset(reset), .flagIN(flagIN), .switches(switches),
      .enterKey(enterKey), .IN(in_s), .inReady(rdy_s), .waiting(wait_s)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every inReady pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && (rdy_u || rdy_s)) begin
         checks++;
         if (sbq.size() == 0) begin
            $display("FAIL unexpected_inReady cyc=%0d got pulse, required none", cyc);
         end else begin
            passes++;
            e = sbq.pop_front();
            checks++;
            if ((rdy_u && rdy_s) !== 1'b1) $display("FAIL rdy_both cyc=%0d got u=%b s=%b required 1/1", cyc, rdy_u, rdy_s);
            else passes++;
            checks++;
            if (in_u !== e.d_u) $display("FAIL in_zero_ext got %h required %h", in_u, e.d_u);
            else passes++;
            checks++;
            if (in_s !== e.d_s) $display("FAIL in_sign_ext got %h required %h", in_s, e.d_s);
            else passes++;
            checks++;
            if (cyc !== e.at) $display("FAIL latency got edge %0d required edge %0d", cyc, e.at);
            else passes++;
            checks++;
            if (wait_u !== 1'b0 || prev_waiting !== 1'b1)
               $display("FAIL waiting_edge got now=%b before=%b required 0/1", wait_u, prev_waiting);
            else passes++;
         end
      end
      prev_waiting = wait_u;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] du, input logic [31:0] ds);
      exp_t e;
      e.d_u = du;
      e.d_s = ds;
      e.at  = cyc + LAT;
      sbq.push_back(e);
      last_u = du;
      last_s = ds;
   endtask

   task automatic wait_drain();
      int b = 0;
      while (sbq.size() != 0 && b < 100) begin
         tick(1);
         b++;
      end
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL drain_timeout got %0d pending required 0", sbq.size());
         sbq.delete();
      end else passes++;
      flagIN = 1'b0;
      tick(6);
   endtask

   task automatic press(input logic [15:0] sv, input logic [31:0] du, input logic [31:0] ds);
      flagIN   = 1'b1;
      switches = sv;
      tick(3);
      checks++;
      if (wait_u !== 1'b1) $display("FAIL armed_waiting got %b required 1", wait_u);
      else passes++;
      enterKey = 1'b1;
      push_exp(du, ds);
      tick(10);
      enterKey = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (in_u !== 32'h0 || in_s !== 32'h0) $display("FAIL reset_in got %h/%h required 0", in_u, in_s);
      else passes++;
      checks++;
      if (rdy_u !== 1'b0 || wait_u !== 1'b0) $display("FAIL reset_ctl got rdy=%b wait=%b required 0/0", rdy_u, wait_u);
      else passes++;
      reset = 1'b0;
      tick(3);
      checks++;
      if (wait_u !== 1'b0) $display("FAIL idle_waiting got %b required 0", wait_u);
      else passes++;
   endtask

   task automatic test_clean_press();
      press(16'h00A5, 32'h000000A5, 32'h000000A5);
   endtask

   task automatic test_bounce();
      flagIN   = 1'b1;
      switches = 16'h1234;
      tick(3);
      enterKey = 1'b1;
      tick(2);
      enterKey = 1'b0;
      tick(1);
      enterKey = 1'b1;
      push_exp(32'h00001234, 32'h00001234);
      tick(6);
      enterKey = 1'b0;
      wait_drain();
   endtask

   task automatic test_held_key();
      enterKey = 1'b1;
      tick(4);
      flagIN   = 1'b1;
      switches = 16'h5A5A;
      tick(20);
      checks++;
      if (wait_u !== 1'b1) $display("FAIL held_waiting got %b required 1", wait_u);
      else passes++;
      enterKey = 1'b0;
      tick(4);
      enterKey = 1'b1;
      push_exp(32'h00005A5A, 32'h00005A5A);
      tick(10);
      enterKey = 1'b0;
      wait_drain();
   endtask

   task automatic test_sign_ext();
      press(16'h8001, 32'h00008001, 32'hFFFF8001);
   endtask

   task automatic test_abort();
      flagIN   = 1'b1;
      switches = 16'hFFFF;
      tick(3);
      enterKey = 1'b1;
      tick(4);
      flagIN = 1'b0;
      tick(1);
      checks++;
      if (wait_u !== 1'b0) $display("FAIL abort_idle got waiting=%b required 0", wait_u);
      else passes++;
      tick(10);
      enterKey = 1'b0;
      tick(4);
      checks++;
      if (in_u !== last_u || in_s !== last_s)
         $display("FAIL abort_in_kept got %h/%h required %h/%h", in_u, in_s, last_u, last_s);
      else passes++;
   endtask

   task automatic test_reset_mid();
      flagIN   = 1'b1;
      switches = 16'h0F0F;
      tick(3);
      enterKey = 1'b1;
      tick(4);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (in_u !== 32'h0 || in_s !== 32'h0 || rdy_u !== 1'b0 || wait_u !== 1'b0)
         $display("FAIL async_reset got in=%h/%h rdy=%b wait=%b required 0", in_u, in_s, rdy_u, wait_u);
      else passes++;
      flagIN = 1'b0;
      last_u = 32'h0;
      last_s = 32'h0;
      tick(3);
      reset = 1'b0;
      tick(2);
      flagIN = 1'b1;
      tick(4);
      enterKey = 1'b0;
      tick(4);
      enterKey = 1'b1;
      push_exp(32'h00000F0F, 32'h00000F0F);
      tick(10);
      enterKey = 1'b0;
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_held_key();
      test_sign_ext();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
